// File: rtl/fft_result_streamer.sv
// fft_result_streamer: buffers one frame of NPTS complex FFT results and
// serialises it as header, sequence number, point bytes and XOR checksum
// on an 8-bit valid/ready byte stream.
module fft_result_streamer #(
    parameter int NPTS = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_re,
    input  logic [15:0]   wr_im,
    input  logic          frame_done,
    input  logic          clr_overrun,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic          overrun
);

    typedef enum logic [2:0] {IDLE, HDR, SEQ, DATA, CSUM} state_t;

    state_t                 state, state_nxt;
    logic [NPTS-1:0][31:0]  mem;
    logic [AW-1:0]          pt;
    logic [1:0]             bi;
    logic [7:0]             seq;
    logic [7:0]             csum;
    logic [31:0]            word;
    logic                   xfer;
    logic                   start;
    logic                   last_pt;

    // Output stream is a pure function of the FSM state, so tx_data holds
    // automatically through stalls and ena=0 freezes.
    assign tx_valid = (state != IDLE);
    assign busy     = (state != IDLE);
    assign xfer     = ena && tx_valid && tx_ready;
    assign start    = ena && (state == IDLE) && frame_done;
    assign word     = mem[pt];
    assign last_pt  = (pt == AW'(NPTS - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else if (ena) state <= state_nxt;
    end

    // Next-state and byte selection
    always_comb begin
        state_nxt = state;
        tx_data   = 8'h00;
        case (state)
            IDLE: if (frame_done) state_nxt = HDR;
            HDR: begin
                tx_data = 8'hA5;
                if (xfer) state_nxt = SEQ;
            end
            SEQ: begin
                tx_data = seq;
                if (xfer) state_nxt = DATA;
            end
            DATA: begin
                case (bi)
                    2'd0:    tx_data = word[31:24];
                    2'd1:    tx_data = word[23:16];
                    2'd2:    tx_data = word[15:8];
                    default: tx_data = word[7:0];
                endcase
                if (xfer && bi == 2'd3 && last_pt) state_nxt = CSUM;
            end
            CSUM: begin
                tx_data = csum;
                if (xfer) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Point/byte cursor for the DATA phase; pt wraps back to 0 after the last point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pt <= '0;
            bi <= 2'd0;
        end else if (start) begin
            pt <= '0;
            bi <= 2'd0;
        end else if (xfer && state == DATA) begin
            bi <= bi + 2'd1;
            if (bi == 2'd3) pt <= pt + 1'b1;
        end
    end

    // Running checksum over every byte actually transferred
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) csum <= 8'h00;
        else if (start) csum <= 8'h00;
        else if (xfer) csum <= csum ^ tx_data;
    end

    // Sequence number advances as the checksum byte leaves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seq <= 8'h00;
        else if (xfer && state == CSUM) seq <= seq + 8'd1;
    end

    // Result buffer: writable only while idle so the frame in flight is stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem <= '0;
        else if (ena && wr_en && state == IDLE) mem[wr_addr] <= {wr_re, wr_im};
    end

    // Sticky overrun: set beats clear when both happen together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overrun <= 1'b0;
        else if (ena && busy && (wr_en || frame_done)) overrun <= 1'b1;
        else if (ena && clr_overrun) overrun <= 1'b0;
    end

endmodule

// File: tb/tb_fft_result_streamer.sv
// Directed bench for fft_result_streamer: a table of frame scenarios
// (stall pattern, ena pause, busy-time injection, expected timing/flags)
// plus hand sequences for reset, mid-frame reset and sequence wrap.
module tb_fft_result_streamer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_re, wr_im;
    logic        frame_done;
    logic        clr_overrun;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        overrun;

    fft_result_streamer #(.NPTS(8), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_re(wr_re), .wr_im(wr_im), .frame_done(frame_done),
        .clr_overrun(clr_overrun), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mode;      // 0: ready held high, 1: ready 1,0,1,0...
        int pat;       // first cycle of ena=0 pause
        int plen;      // pause length (0 = none)
        int inj;       // cycle of busy-time write+frame_done (0 = none)
        bit inj_clr;   // clr_overrun together with the injection
        bit wr0;       // write point 7 in the same cycle as frame_done
        bit post_clr;  // lone clr_overrun after the frame
        int last;      // cycle index (after frame_done edge) of last accept
        bit ovr;       // overrun expected after the frame
    } scen_t;

    int          nerr = 0;
    int          nchk = 0;
    logic [15:0] tb_re [8];
    logic [15:0] tb_im [8];
    logic [7:0]  exp_seq;
    logic [7:0]  cap[$];
    int          last_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cmp_frame(input logic [7:0] s);
        logic [7:0] e [35];
        logic [7:0] c;
        c = 8'h00;
        e[0] = 8'hA5;
        e[1] = s;
        for (int i = 0; i < 8; i++) begin
            e[2+4*i] = tb_re[i][15:8];
            e[3+4*i] = tb_re[i][7:0];
            e[4+4*i] = tb_im[i][15:8];
            e[5+4*i] = tb_im[i][7:0];
        end
        for (int k = 0; k < 34; k++) c = c ^ e[k];
        e[34] = c;
        chk("frame_len", cap.size(), 35);
        for (int k = 0; k < cap.size() && k < 35; k++)
            chk($sformatf("byte%0d_seq%0h", k, s), {24'h0, cap[k]}, {24'h0, e[k]});
    endtask

    task automatic run_frame(input scen_t s);
        int         n;
        logic       pend;
        logic [7:0] held;
        cap.delete();
        last_n = 0;
        pend = 1'b0;
        held = 8'h00;
        n = 0;
        @(negedge clk);
        frame_done = 1'b1;
        tx_ready = 1'b1;
        ena = 1'b1;
        if (s.wr0) begin
            wr_en = 1'b1; wr_addr = 3'd7; wr_re = 16'h1007; wr_im = 16'h2007;
            tb_re[7] = 16'h1007; tb_im[7] = 16'h2007;
        end
        while (cap.size() < 35 && n < 300) begin
            @(negedge clk);
            n++;
            frame_done = 1'b0; wr_en = 1'b0; clr_overrun = 1'b0;
            ena = !(s.plen > 0 && n >= s.pat && n < s.pat + s.plen);
            tx_ready = (s.mode == 0) || (n % 2 == 1);
            if (n == s.inj) begin
                wr_en = 1'b1; wr_addr = 3'd3; wr_re = 16'hFFFF; wr_im = 16'hFFFF;
                frame_done = 1'b1; clr_overrun = s.inj_clr;
            end
            if (n == 1) begin
                chk("start_busy", busy, 1);
                chk("start_valid", tx_valid, 1);
            end
            if (pend) chk("stall_hold", tx_data, held);
            if (tx_valid && tx_ready && ena) begin
                cap.push_back(tx_data);
                last_n = n;
                pend = 1'b0;
            end else begin
                pend = tx_valid;
                held = tx_data;
            end
        end
        @(negedge clk);
        wr_en = 1'b0; frame_done = 1'b0; clr_overrun = 1'b0; ena = 1'b1; tx_ready = 1'b0;
        chk("end_busy", busy, 0);
        chk("end_valid", tx_valid, 0);
        chk("last_cycle", last_n, s.last);
        chk("overrun", overrun, s.ovr);
        cmp_frame(exp_seq);
        exp_seq = exp_seq + 8'd1;
    endtask

    scen_t tbl [6];
    scen_t plain;

    initial begin
        plain  = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 35, 1'b0};
        tbl[0] = '{0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 35, 1'b0};  // write+commit same cycle
        tbl[1] = '{1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 69, 1'b0};  // 35 accepts, 34 stalls
        tbl[2] = '{0, 10, 5, 0, 1'b0, 1'b0, 1'b0, 40, 1'b0}; // ena low 5 cycles
        tbl[3] = '{0, 0, 0, 12, 1'b0, 1'b0, 1'b1, 35, 1'b1}; // busy-time write+commit
        tbl[4] = '{0, 0, 0, 35, 1'b1, 1'b0, 1'b1, 35, 1'b1}; // CSUM cycle, set beats clear
        tbl[5] = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 35, 1'b0};  // buffer still original

        rst_n = 1'b0; ena = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_re = 16'h0; wr_im = 16'h0;
        frame_done = 1'b0; clr_overrun = 1'b0; tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin tb_re[i] = 16'h0; tb_im[i] = 16'h0; end
        exp_seq = 8'h00;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_data", tx_data, 0);
        @(negedge clk) rst_n = 1'b1;

        // unwritten buffer: A5,00, 32x00, A5
        run_frame(plain);

        // points 0..6 now; point 7 goes in with the commit
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 3'(i); wr_re = 16'h1000 + 16'(i); wr_im = 16'h2000 + 16'(i);
            tb_re[i] = 16'h1000 + 16'(i); tb_im[i] = 16'h2000 + 16'(i);
        end
        @(negedge clk) wr_en = 1'b0;

        for (int t = 0; t < 6; t++) begin
            run_frame(tbl[t]);
            if (tbl[t].post_clr) begin
                @(negedge clk) clr_overrun = 1'b1;
                @(negedge clk) clr_overrun = 1'b0;
                chk("clr_overrun", overrun, 0);
            end
        end

        // async reset after the 10th byte
        @(negedge clk);
        frame_done = 1'b1; tx_ready = 1'b1;
        @(negedge clk) frame_done = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", tx_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_data", tx_data, 0);
        for (int i = 0; i < 8; i++) begin tb_re[i] = 16'h0; tb_im[i] = 16'h0; end
        exp_seq = 8'h00;
        @(negedge clk);
        rst_n = 1'b1; tx_ready = 1'b0;

        // 257 zero frames: seq 00..FF,00, checksum A5^seq
        for (int f = 0; f < 257; f++) begin
            run_frame(plain);
            if (f == 255 && cap.size() == 35) chk("csum_seq_ff", {24'h0, cap[34]}, 32'h5A);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
